// File: rtl/gpio_msg_receiver.sv
// Four-phase GPIO byte receiver: collects NUM_BYTES ASCII bytes into a shadow buffer
// and publishes them as one message, with a mid-frame watchdog and a sticky abort flag.
module gpio_msg_receiver #(
  parameter int NUM_BYTES      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx_enable,
  input  logic                     link_req,
  input  logic [7:0]               link_data,
  output logic                     link_ack,
  output logic [8*NUM_BYTES-1:0]   message_in,
  output logic                     message_valid,
  output logic [4:0]               byte_count,
  output logic                     busy,
  output logic                     frame_error
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_REQ = 3'd1,
    ACK_HIGH = 3'd2,
    COMPLETE = 3'd3,
    FLUSH    = 3'd4
  } state_t;

  localparam logic [15:0] WD_LIMIT   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]  LAST_COUNT = 5'(NUM_BYTES);

  state_t state_reg, state_next;
  logic                   sync1_reg;
  logic                   req_s;
  logic [15:0]            wdog_reg;
  logic [4:0]             count_reg;
  logic [4:0]             count_inc;
  logic                   ack_reg, ack_next;
  logic                   valid_reg;
  logic                   error_reg;
  logic [8*NUM_BYTES-1:0] message_reg;
  logic [8*NUM_BYTES-1:0] shadow_flat;

  logic counting, timeout, capture, abort_rx, ack_done, last_byte, enter_complete;

  // link_req is asynchronous; only req_s may be used past this point.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      req_s     <= 1'b0;
    end else begin
      sync1_reg <= link_req;
      req_s     <= sync1_reg;
    end
  end

  assign count_inc      = count_reg + 5'd1;
  assign last_byte      = (count_inc == LAST_COUNT);
  assign counting       = (state_reg == ACK_HIGH) ||
                          ((state_reg == WAIT_REQ) && (count_reg != 5'd0));
  assign timeout        = counting && (wdog_reg == WD_LIMIT);
  assign capture        = (state_reg == WAIT_REQ) && req_s && !timeout;
  assign abort_rx       = (state_reg == WAIT_REQ) && !req_s && !rx_enable &&
                          (count_reg != 5'd0) && !timeout;
  assign ack_done       = (state_reg == ACK_HIGH) && !req_s && !timeout;
  assign enter_complete = ack_done && last_byte;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= ack_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (rx_enable) state_next = WAIT_REQ;
      end
      WAIT_REQ: begin
        if (timeout)         state_next = FLUSH;
        else if (req_s)      state_next = ACK_HIGH;
        else if (!rx_enable) state_next = IDLE;
      end
      ACK_HIGH: begin
        if (timeout)     state_next = FLUSH;
        else if (!req_s) state_next = last_byte ? COMPLETE : WAIT_REQ;
      end
      COMPLETE: begin
        state_next = rx_enable ? WAIT_REQ : IDLE;
      end
      FLUSH: begin
        if (!req_s) state_next = rx_enable ? WAIT_REQ : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // link_ack is registered from the next state so it tracks ACK_HIGH/FLUSH exactly.
  always_comb begin
    ack_next = (state_next == ACK_HIGH) || (state_next == FLUSH);
  end

  // Watchdog restarts on every state change, so it measures time spent in one state.
  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_reg <= 16'd0;
    end else if (state_next != state_reg) begin
      wdog_reg <= 16'd0;
    end else if (counting) begin
      wdog_reg <= wdog_reg + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= 5'd0;
    end else if (timeout || abort_rx || (state_reg == COMPLETE)) begin
      count_reg <= 5'd0;
    end else if (ack_done) begin
      count_reg <= last_byte ? 5'd0 : count_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      error_reg <= 1'b0;
    end else if (timeout || abort_rx) begin
      error_reg <= 1'b1;
    end else if (capture && (count_reg == 5'd0)) begin
      error_reg <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi = gi + 1) begin : g_slot
      logic [7:0] slot_reg;
      always_ff @(posedge clock) begin
        if (reset) begin
          slot_reg <= 8'd0;
        end else if (capture && (count_reg == 5'(gi))) begin
          slot_reg <= link_data;
        end
      end
      // Byte 0 lands in the most significant position of the message.
      assign shadow_flat[8*(NUM_BYTES-1-gi) +: 8] = slot_reg;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      message_reg <= '0;
      valid_reg   <= 1'b0;
    end else begin
      valid_reg <= enter_complete;
      if (enter_complete) message_reg <= shadow_flat;
    end
  end

  assign link_ack      = ack_reg;
  assign message_in    = message_reg;
  assign message_valid = valid_reg;
  assign byte_count    = count_reg;
  assign frame_error   = error_reg;
  assign busy          = (count_reg != 5'd0) ||
                         !((state_reg == IDLE) || (state_reg == WAIT_REQ));

endmodule

// File: tb/tb_gpio_msg_receiver.sv
// Self-checking bench for gpio_msg_receiver: directed scenarios with randomized bytes
// and gaps, compared against a queue-based frame model.
module tb_gpio_msg_receiver;
  localparam int NB = 16;
  localparam int TO = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         rx_enable = 1'b0;
  logic         link_req = 1'b0;
  logic [7:0]   link_data = 8'd0;
  logic         link_ack;
  logic [127:0] message_in;
  logic         message_valid;
  logic [4:0]   byte_count;
  logic         busy;
  logic         frame_error;

  gpio_msg_receiver #(.NUM_BYTES(NB), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .rx_enable(rx_enable), .link_req(link_req),
    .link_data(link_data), .link_ack(link_ack), .message_in(message_in),
    .message_valid(message_valid), .byte_count(byte_count), .busy(busy),
    .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int ack_rises = 0;
  logic prev_ack = 1'b0;

  logic [7:0]   frame_q[$];
  logic [127:0] exp_msg = '0;
  logic         exp_err = 1'b0;
  int           exp_valid = 0;

  always @(negedge clock) begin
    if (message_valid === 1'b1) valid_cnt++;
    if (link_ack === 1'b1 && prev_ack === 1'b0) ack_rises++;
    prev_ack = link_ack;
  end

  initial begin
    #500us;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack_q();
    logic [127:0] r = '0;
    foreach (frame_q[i]) r = {r[119:0], frame_q[i]};
    return r;
  endfunction

  task automatic model_push(input logic [7:0] b);
    if (frame_q.size() == 0) exp_err = 1'b0;
    frame_q.push_back(b);
    if (frame_q.size() == NB) begin
      exp_msg = pack_q();
      exp_valid++;
      frame_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_ack(input logic val, input string tag);
    int n = 0;
    while (link_ack !== val && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 128'(link_ack), 128'(val));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(negedge clock);
      link_data = 8'($urandom_range(0, 255));
    end
    @(negedge clock);
    link_data = b;
    link_req = 1'b1;
    wait_ack(1'b1, "ack_rise");
    link_req = 1'b0;
    link_data = 8'($urandom_range(0, 255));
    wait_ack(1'b0, "ack_fall");
    model_push(b);
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(8'($urandom_range(32, 126)), $urandom_range(0, 6));
      chk("byte_count_step", 128'(byte_count), 128'(frame_q.size()));
    end
  endtask

  task automatic check_state(input string tag);
    idle(3);
    chk({tag, "_msg"}, message_in, exp_msg);
    chk({tag, "_count"}, 128'(byte_count), 128'(frame_q.size()));
    chk({tag, "_err"}, 128'(frame_error), 128'(exp_err));
    chk({tag, "_valids"}, 128'(valid_cnt), 128'(exp_valid));
    $display("txn %s msg=%h count=%0d err=%0b valids=%0d", tag, message_in, byte_count,
             frame_error, valid_cnt);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"}, 128'(link_ack), 128'(0));
    chk({tag, "_msg"}, message_in, 128'(0));
    chk({tag, "_valid"}, 128'(message_valid), 128'(0));
    chk({tag, "_count"}, 128'(byte_count), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_err"}, 128'(frame_error), 128'(0));
  endtask

  initial begin
    string s;
    int a0;
    int n;
    logic [127:0] z_msg;

    // Reset state
    reset = 1'b1;
    idle(3);
    check_zero("reset");
    reset = 1'b0;
    rx_enable = 1'b1;
    idle(3);

    // Known ASCII frame, including message_valid on the last ack fall
    s = "abcdefghijklmnop";
    a0 = ack_rises;
    for (int i = 0; i < NB; i++) begin
      send_byte(s[i], $urandom_range(0, 3));
      chk("abc_count", 128'(byte_count), 128'(frame_q.size()));
    end
    chk("abc_valid_latency", 128'(message_valid), 128'(1));
    check_state("abc");
    chk("abc_const", message_in, 128'h6162636465666768696a6b6c6d6e6f70);
    chk("abc_ack_toggles", 128'(ack_rises - a0), 128'(16));

    // Random frames with random gaps and data churn between bytes
    for (int f = 0; f < 3; f++) begin
      send_random(NB);
      check_state("rand_frame");
    end

    // Mid-frame watchdog timeout while waiting for the next byte
    send_random(5);
    idle(4);
    chk("pre_timeout_err", 128'(frame_error), 128'(0));
    idle(TO + 8);
    frame_q.delete();
    exp_err = 1'b1;
    check_state("timeout");
    chk("timeout_busy", 128'(busy), 128'(0));
    send_random(1);
    chk("err_cleared_byte0", 128'(frame_error), 128'(0));
    send_random(NB - 1);
    check_state("after_timeout");

    // Sender stuck high: FLUSH holds ack, no capture
    @(negedge clock);
    link_data = 8'($urandom_range(32, 126));
    link_req = 1'b1;
    wait_ack(1'b1, "flush_ack_rise");
    idle(TO + 10);
    chk("flush_ack_held", 128'(link_ack), 128'(1));
    chk("flush_err", 128'(frame_error), 128'(1));
    chk("flush_count", 128'(byte_count), 128'(0));
    link_req = 1'b0;
    n = 0;
    while (link_ack === 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("flush_release_latency", 128'((n >= 2) && (n <= 3)), 128'(1));
    exp_err = 1'b1;
    check_state("flush");

    // rx_enable dropped while waiting mid-frame
    send_random(3);
    @(negedge clock);
    rx_enable = 1'b0;
    idle(4);
    frame_q.delete();
    exp_err = 1'b1;
    chk("rxoff_count", 128'(byte_count), 128'(0));
    chk("rxoff_err", 128'(frame_error), 128'(1));
    chk("rxoff_busy", 128'(busy), 128'(0));
    rx_enable = 1'b1;
    idle(2);

    // rx_enable dropped during ACK_HIGH: handshake completes first
    @(negedge clock);
    link_data = 8'h41;
    link_req = 1'b1;
    wait_ack(1'b1, "rxack_rise");
    rx_enable = 1'b0;
    link_req = 1'b0;
    wait_ack(1'b0, "rxack_fall");
    chk("rxack_count_incr", 128'(byte_count), 128'(1));
    idle(4);
    chk("rxack_abort_err", 128'(frame_error), 128'(1));
    chk("rxack_abort_count", 128'(byte_count), 128'(0));
    rx_enable = 1'b1;
    exp_err = 1'b1;
    check_state("rxack");

    // Reset in the middle of byte 9's handshake, sender keeps link_req high
    send_random(9);
    @(negedge clock);
    link_data = 8'h7A;
    link_req = 1'b1;
    wait_ack(1'b1, "rst_ack_rise");
    reset = 1'b1;
    @(negedge clock);
    check_zero("midreset");
    reset = 1'b0;
    exp_msg = '0;
    frame_q.delete();
    exp_err = 1'b0;
    wait_ack(1'b1, "rst_recapture_rise");
    link_req = 1'b0;
    wait_ack(1'b0, "rst_recapture_fall");
    model_push(8'h7A);
    chk("rst_byte0_count", 128'(byte_count), 128'(1));
    for (int i = 1; i < NB; i++) send_byte(8'h7A, $urandom_range(0, 4));
    check_state("zzz");
    z_msg = {16{8'h7A}};
    chk("zzz_const", message_in, z_msg);

    // Sub-cycle glitches on link_req between clock edges
    send_random(4);
    for (int g = 0; g < 4; g++) begin
      @(negedge clock);
      link_data = 8'($urandom_range(0, 255));
      #1 link_req = 1'b1;
      #2 link_req = 1'b0;
    end
    idle(3);
    chk("glitch_count", 128'(byte_count), 128'(4));
    send_random(NB - 4);
    check_state("glitch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
